ahbl_splitter_n: RTL and testbench

AHBL_SPLITTER_N -- requirements
Module: ahbl_splitter_n

---
 rtl/ahbl_splitter_n.sv | 122 ++++++++++++
 tb/tb_ahbl_splitter_n.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_splitter_n.sv
// rtl/ahbl_splitter_n.sv - AHB-Lite 1:N address splitter with built-in default (error) slave
// Decodes HADDR[31:28] to a slave select and muxes the data-phase response back to the master.
module ahbl_splitter_n #(
    parameter int                NS        = 4,
    parameter logic [NS*4-1:0]   S_BASE    = {4'h8, 4'h4, 4'h2, 4'h0},
    parameter logic [31:0]       DEF_RDATA = 32'hBADDBEEF
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    output logic                 HREADY,
    output logic [31:0]          HRDATA,
    output logic                 HRESP,
    output logic [NS-1:0]        S_HSEL,
    input  logic [NS*32-1:0]     S_HRDATA,
    input  logic [NS-1:0]        S_HREADYOUT,
    input  logic [NS-1:0]        S_HRESP,
    output logic [7:0]           ERR_COUNT,
    output logic [31:0]          ERR_ADDR
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t      ds_state_q, ds_state_d;
    logic [NS-1:0]  dsel_q, dsel_d;
    logic [7:0]     err_count_q, err_count_d;
    logic [31:0]    err_addr_q, err_addr_d;
    logic [NS-1:0]  hsel;
    logic           hit;
    logic           unmapped_acc;
    logic           unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Lowest index wins when two slaves share a base nibble.
    always_comb begin
        hsel = '0;
        hit  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!hit && (HADDR[31:28] == S_BASE[i*4 +: 4])) begin
                hsel[i] = 1'b1;
                hit     = 1'b1;
            end
        end
    end

    assign S_HSEL       = hsel;
    assign unmapped_acc = HREADY & HTRANS[1] & ~hit;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ds_state_q  <= DS_IDLE;
            dsel_q      <= '0;
            err_count_q <= 8'h00;
            err_addr_q  <= 32'h0;
        end else begin
            ds_state_q  <= ds_state_d;
            dsel_q      <= dsel_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // An unmapped acceptance clears dsel, so the default slave and a real slave never overlap.
    always_comb begin
        ds_state_d  = ds_state_q;
        dsel_d      = dsel_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        if (HREADY) begin
            dsel_d = HTRANS[1] ? hsel : '0;
        end
        if (unmapped_acc) begin
            err_addr_d = HADDR;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'h01;
            end
        end
        case (ds_state_q)
            DS_IDLE: ds_state_d = unmapped_acc ? DS_ERR1 : DS_IDLE;
            DS_ERR1: ds_state_d = DS_ERR2;
            DS_ERR2: ds_state_d = unmapped_acc ? DS_ERR1 : DS_IDLE;
            default: ds_state_d = DS_IDLE;
        endcase
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        case (ds_state_q)
            DS_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
                HRDATA = DEF_RDATA;
            end
            DS_ERR2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
                HRDATA = DEF_RDATA;
            end
            default: begin
                for (int i = 0; i < NS; i++) begin
                    if (dsel_q[i]) begin
                        HREADY = S_HREADYOUT[i];
                        HRESP  = S_HRESP[i];
                        HRDATA = S_HRDATA[i*32 +: 32];
                    end
                end
            end
        endcase
    end

    assign ERR_COUNT = err_count_q;
    assign ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// tb/tb_ahbl_splitter_n.sv - self-checking bench for ahbl_splitter_n
// Decode table, directed corner sequences and a randomized run against a transfer-level model.
module tb_ahbl_splitter_n;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic [31:0]  HRDATA;
    logic         HRESP;
    logic [3:0]   S_HSEL;
    logic [127:0] S_HRDATA;
    logic [3:0]   S_HREADYOUT;
    logic [3:0]   S_HRESP;
    logic [7:0]   ERR_COUNT;
    logic [31:0]  ERR_ADDR;

    ahbl_splitter_n dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .S_HSEL(S_HSEL),
        .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
        .ERR_COUNT(ERR_COUNT), .ERR_ADDR(ERR_ADDR)
    );

    always #5 HCLK = ~HCLK;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [3:0]  exp_hsel;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Transfer-level model: what the current data phase is and how far the error response has got.
    int          m_kind;
    int          m_slave;
    int          m_errcyc;
    int          m_count;
    logic [31:0] m_addr;
    logic [3:0]  bases [4] = '{4'h0, 4'h2, 4'h4, 4'h8};

    logic        a_ready, a_resp;
    logic [31:0] a_rdata;
    logic [3:0]  a_hsel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int dec(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a[31:28] == bases[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_kind = 0; m_slave = 0; m_errcyc = 0; m_count = 0; m_addr = 32'h0;
    endtask

    task automatic step(input logic [31:0] a, input logic [1:0] t, input string tag);
        logic [3:0]  e_hsel;
        logic        e_ready, e_resp;
        logic [31:0] e_rdata;
        int          d;
        HADDR  = a;
        HTRANS = t;
        @(negedge HCLK);
        d      = dec(a);
        e_hsel = (d >= 0) ? 4'(1 << d) : 4'b0000;
        case (m_kind)
            1: begin
                e_ready = S_HREADYOUT[m_slave];
                e_resp  = S_HRESP[m_slave];
                e_rdata = S_HRDATA[m_slave*32 +: 32];
            end
            2: begin
                e_ready = (m_errcyc == 1);
                e_resp  = 1'b1;
                e_rdata = 32'hBADDBEEF;
            end
            default: begin
                e_ready = 1'b1;
                e_resp  = 1'b0;
                e_rdata = 32'h0;
            end
        endcase
        a_ready = HREADY; a_resp = HRESP; a_rdata = HRDATA; a_hsel = S_HSEL;
        chk({tag, ".hsel"},   32'(S_HSEL), 32'(e_hsel));
        chk({tag, ".hready"}, 32'(HREADY), 32'(e_ready));
        chk({tag, ".hresp"},  32'(HRESP),  32'(e_resp));
        chk({tag, ".hrdata"}, HRDATA,      e_rdata);
        chk({tag, ".errcnt"}, 32'(ERR_COUNT), 32'(m_count));
        chk({tag, ".erraddr"}, ERR_ADDR,   m_addr);
        @(posedge HCLK);
        if (e_ready) begin
            if (t[1]) begin
                if (d >= 0) begin
                    m_kind = 1; m_slave = d;
                end else begin
                    m_kind = 2; m_errcyc = 0;
                    m_count = (m_count < 255) ? m_count + 1 : 255;
                    m_addr = a;
                end
            end else begin
                m_kind = 0;
            end
        end else if (m_kind == 2) begin
            m_errcyc = 1;
        end
        #1;
    endtask

    task automatic pulse_reset();
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        model_reset();
    endtask

    vec_t vecs [8];
    int   low_cycles;
    int   cnt_before;

    initial begin
        vecs[0] = '{32'h0000_0000, NSEQ, 4'b0001};
        vecs[1] = '{32'h2000_0010, NSEQ, 4'b0010};
        vecs[2] = '{32'h4000_0000, IDLE, 4'b0100};
        vecs[3] = '{32'h8FFF_FFFC, SEQ,  4'b1000};
        vecs[4] = '{32'hC000_0000, NSEQ, 4'b0000};
        vecs[5] = '{32'h1000_0000, BUSY, 4'b0000};
        vecs[6] = '{32'hFFFF_FFFF, SEQ,  4'b0000};
        vecs[7] = '{32'h2FFF_0000, BUSY, 4'b0010};

        HRESET = 1'b1; HADDR = 32'h0; HTRANS = IDLE;
        S_HREADYOUT = 4'hF; S_HRESP = 4'h0;
        S_HRDATA = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        model_reset();
        #12;
        chk("rst.hready", 32'(HREADY), 32'd1);
        chk("rst.hresp",  32'(HRESP),  32'd0);
        chk("rst.hrdata", HRDATA, 32'h0);
        chk("rst.errcnt", 32'(ERR_COUNT), 32'd0);
        chk("rst.erraddr", ERR_ADDR, 32'h0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        // Single unmapped transfer straight out of reset.
        step(32'hC000_0000, NSEQ, "err1.a");
        step(32'h0, IDLE, "err1.d1");
        chk("err1.d1_ready", 32'(a_ready), 32'd0);
        chk("err1.d1_resp",  32'(a_resp),  32'd1);
        chk("err1.d1_rdata", a_rdata, 32'hBADDBEEF);
        step(32'h0, IDLE, "err1.d2");
        chk("err1.d2_ready", 32'(a_ready), 32'd1);
        chk("err1.d2_resp",  32'(a_resp),  32'd1);
        chk("err1.count", 32'(ERR_COUNT), 32'd1);
        chk("err1.addr",  ERR_ADDR, 32'hC000_0000);

        // Back-to-back unmapped, then a mapped transfer taken in the second error cycle.
        pulse_reset();
        step(32'hC000_0000, NSEQ, "b2b.s1");
        step(32'hD000_0004, NSEQ, "b2b.s2");
        chk("b2b.s2_ready", 32'(a_ready), 32'd0);
        step(32'hD000_0004, NSEQ, "b2b.s3");
        chk("b2b.s3_ready", 32'(a_ready), 32'd1);
        chk("b2b.s3_resp",  32'(a_resp),  32'd1);
        step(32'h0000_0000, NSEQ, "b2b.s4");
        chk("b2b.s4_ready", 32'(a_ready), 32'd0);
        step(32'h0000_0000, NSEQ, "b2b.s5");
        chk("b2b.s5_resp",  32'(a_resp),  32'd1);
        step(32'h0, IDLE, "b2b.s6");
        chk("b2b.s6_ready", 32'(a_ready), 32'd1);
        chk("b2b.s6_resp",  32'(a_resp),  32'd0);
        chk("b2b.s6_rdata", a_rdata, 32'hA000_0000);
        chk("b2b.count", 32'(ERR_COUNT), 32'd2);
        chk("b2b.addr",  ERR_ADDR, 32'hD000_0004);

        // Decode table.
        foreach (vecs[i]) begin
            step(vecs[i].addr, vecs[i].trans, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.hsel_const", i), 32'(a_hsel), 32'(vecs[i].exp_hsel));
        end
        step(32'h0, IDLE, "tbl.drain");
        step(32'h0, IDLE, "tbl.drain2");

        // Slave1 read.
        S_HRDATA[63:32] = 32'h1234_5678;
        step(32'h2000_0010, NSEQ, "rd1.a");
        chk("rd1.hsel", 32'(a_hsel), 32'h2);
        step(32'h0, IDLE, "rd1.d");
        chk("rd1.rdata", a_rdata, 32'h1234_5678);
        chk("rd1.ready", 32'(a_ready), 32'd1);

        // Slave2 with three wait states; the address changes during the waits.
        step(32'h4000_0000, NSEQ, "wt.a");
        S_HREADYOUT[2] = 1'b0;
        low_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            step(32'h8000_0000, NSEQ, "wt.w");
            if (!a_ready) low_cycles++;
        end
        S_HREADYOUT[2] = 1'b1;
        step(32'h0, IDLE, "wt.end");
        if (!a_ready) low_cycles++;
        chk("wt.low_cycles", 32'(low_cycles), 32'd3);
        chk("wt.last_rdata", a_rdata, 32'hA000_0002);

        // IDLE to a mapped address selects combinationally but has no data phase.
        cnt_before = m_count;
        step(32'h4000_0000, IDLE, "idle.a");
        chk("idle.hsel", 32'(a_hsel), 32'h4);
        step(32'h0, IDLE, "idle.d");
        chk("idle.rdata", a_rdata, 32'h0);
        chk("idle.count", 32'(ERR_COUNT), 32'(cnt_before));

        // Reset during a slave wait state.
        S_HREADYOUT[0] = 1'b0;
        step(32'h0000_0000, NSEQ, "rw.a");
        step(32'h0, IDLE, "rw.w");
        HRESET = 1'b1;
        #1;
        chk("rw.ready", 32'(HREADY), 32'd1);
        pulse_reset();
        S_HREADYOUT[0] = 1'b1;
        step(32'h0, IDLE, "rw.after");

        // Saturation, then reset in the middle of the first error cycle.
        for (int k = 0; k < 601; k++) step(32'hC000_0000, NSEQ, "sat");
        chk("sat.count", 32'(ERR_COUNT), 32'hFF);
        HTRANS = IDLE;
        HRESET = 1'b1;
        #1;
        chk("sat.rst_ready", 32'(HREADY), 32'd1);
        chk("sat.rst_resp",  32'(HRESP),  32'd0);
        chk("sat.rst_count", 32'(ERR_COUNT), 32'd0);
        chk("sat.rst_addr",  ERR_ADDR, 32'h0);
        pulse_reset();
        step(32'h0, IDLE, "sat.after");

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [3:0] nib;
            logic [3:0] pick [7];
            pick = '{4'h0, 4'h2, 4'h4, 4'h8, 4'hC, 4'hD, 4'(($urandom))};
            nib  = pick[$urandom_range(0, 6)];
            for (int s = 0; s < 4; s++) S_HREADYOUT[s] = ($urandom_range(0, 3) != 0);
            S_HRESP  = 4'($urandom);
            S_HRDATA = {$urandom, $urandom, $urandom, $urandom};
            step({nib, 28'($urandom)}, 2'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
